// File: rtl/cursor_select_ctrl_pkg.sv
// Shared chess definitions for the cursor/select controller.
// Holds piece codes, colours, FSM state encoding and square/board helpers.
package chess_pkg;

   localparam int unsigned ADDR_W  = 6;
   localparam int unsigned COORD_W = 3;
   localparam int unsigned SQ_W    = 4;
   localparam int unsigned BOARD_W = 256;

   localparam logic [2:0] PIECE_NONE   = 3'd0;
   localparam logic [2:0] PIECE_PAWN   = 3'd1;
   localparam logic [2:0] PIECE_KNIGHT = 3'd2;
   localparam logic [2:0] PIECE_BISHOP = 3'd3;
   localparam logic [2:0] PIECE_ROOK   = 3'd4;
   localparam logic [2:0] PIECE_QUEEN  = 3'd5;
   localparam logic [2:0] PIECE_KING   = 3'd6;

   localparam logic COLOR_WHITE = 1'b0;
   localparam logic COLOR_BLACK = 1'b1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SELECTED = 2'd1,
      REQUEST  = 2'd2
   } state_e;

   typedef struct packed {
      logic       color;
      logic [2:0] kind;
   } piece_t;

   function automatic logic [COORD_W-1:0] sq_row(input logic [ADDR_W-1:0] addr);
      return addr[5:3];
   endfunction

   function automatic logic [COORD_W-1:0] sq_col(input logic [ADDR_W-1:0] addr);
      return addr[2:0];
   endfunction

   // Square n occupies board bits [4n+3:4n].
   function automatic piece_t sq_piece(input logic [BOARD_W-1:0] board,
                                       input logic [ADDR_W-1:0]  addr);
      return piece_t'(board[{addr, 2'b00} +: SQ_W]);
   endfunction

endpackage

// File: rtl/cursor_select_ctrl_if.sv
// Bus between the cursor/select controller and its environment
// (buttons, board state, renderer outputs, engine move handshake).
// Modports:
//   master - the controller: takes buttons/board/engine reply, drives display and move request
//   slave  - the environment: drives buttons/board/engine reply, observes the controller
interface cursor_select_ctrl_if;
   import chess_pkg::*;

   logic                BTN_UP;
   logic                BTN_DOWN;
   logic                BTN_LEFT;
   logic                BTN_RIGHT;
   logic                BTN_CENTER;
   logic [BOARD_W-1:0]  BOARD;
   logic [ADDR_W-1:0]   CURSOR_ADDR;
   logic [ADDR_W-1:0]   SELECT_ADDR;
   logic                SELECT_EN;
   logic [ADDR_W-1:0]   MOVE_SRC;
   logic [ADDR_W-1:0]   MOVE_DST;
   logic                MOVE_VALID;
   logic                MOVE_READY;
   logic                MOVE_LEGAL;
   logic                PLAYER;

   modport master (
      input  BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTER, BOARD,
      input  MOVE_READY, MOVE_LEGAL,
      output CURSOR_ADDR, SELECT_ADDR, SELECT_EN,
      output MOVE_SRC, MOVE_DST, MOVE_VALID, PLAYER
   );

   modport slave (
      output BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTER, BOARD,
      output MOVE_READY, MOVE_LEGAL,
      input  CURSOR_ADDR, SELECT_ADDR, SELECT_EN,
      input  MOVE_SRC, MOVE_DST, MOVE_VALID, PLAYER
   );

endinterface

// File: rtl/cursor_select_ctrl_mover.sv
// cursor_mover: registered {row,col} board cursor.
// Ports: clk, rst (sync active-high), up/down/left/right pulses, en (cursor may move),
//        cursor (registered address).
// One direction acts per cycle, priority up > down > left > right.
// Edge behaviour: CURSOR_WRAP_EN defined -> wrap around, undefined -> saturate.
module cursor_mover
   import chess_pkg::*;
#(
   parameter logic [ADDR_W-1:0] START = 6'o64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              up,
   input  logic              down,
   input  logic              left,
   input  logic              right,
   input  logic              en,
   output logic [ADDR_W-1:0] cursor
);

   logic [COORD_W-1:0] row_n;
   logic [COORD_W-1:0] col_n;

   function automatic logic [COORD_W-1:0] step_dec(input logic [COORD_W-1:0] v);
`ifdef CURSOR_WRAP_EN
      return v - 3'd1;
`else
      return (v == 3'd0) ? v : v - 3'd1;
`endif
   endfunction

   function automatic logic [COORD_W-1:0] step_inc(input logic [COORD_W-1:0] v);
`ifdef CURSOR_WRAP_EN
      return v + 3'd1;
`else
      return (v == 3'd7) ? v : v + 3'd1;
`endif
   endfunction

   // Next coordinates from the highest-priority direction pulse.
   always_comb begin
      row_n = sq_row(cursor);
      col_n = sq_col(cursor);
      if (up)         row_n = step_dec(sq_row(cursor));
      else if (down)  row_n = step_inc(sq_row(cursor));
      else if (left)  col_n = step_dec(sq_col(cursor));
      else if (right) col_n = step_inc(sq_col(cursor));
   end

   always_ff @(posedge clk) begin
      if (rst)     cursor <= START;
      else if (en) cursor <= {row_n, col_n};
   end

endmodule

// File: rtl/cursor_select_ctrl.sv
// cursor_select_ctrl: user-side sequencer for the chess board display.
// Turns button pulses into cursor/selection outputs for the renderer, checks that a
// selected square holds the mover's own piece, issues move requests to the board
// engine with a valid/ready handshake and tracks the side to move.
// Ports: CLK, RESET (sync active-high), bus (cursor_select_ctrl_if.master: buttons,
//        BOARD, CURSOR_ADDR/SELECT_ADDR/SELECT_EN, MOVE_SRC/DST/VALID/READY/LEGAL, PLAYER).
// Build option: CURSOR_WRAP_EN selects wrapping instead of saturating cursor edges.
module cursor_select_ctrl
   import chess_pkg::*;
#(
   parameter logic [ADDR_W-1:0] START_CURSOR = 6'o64,
   parameter logic              FIRST_PLAYER = COLOR_WHITE
) (
   input  logic                 CLK,
   input  logic                 RESET,
   cursor_select_ctrl_if.master bus
);

   state_e             state_q,    state_d;
   logic [ADDR_W-1:0]  sel_addr_q, sel_addr_d;
   logic               sel_en_q,   sel_en_d;
   logic [ADDR_W-1:0]  src_q,      src_d;
   logic [ADDR_W-1:0]  dst_q,      dst_d;
   logic               valid_q,    valid_d;
   logic               player_q,   player_d;
   logic [ADDR_W-1:0]  cursor;
   piece_t             cur_piece;
   logic               own_cur;

   // Cursor is frozen while a move request is outstanding.
   cursor_mover #(.START(START_CURSOR)) u_cursor (
      .clk    (CLK),
      .rst    (RESET),
      .up     (bus.BTN_UP),
      .down   (bus.BTN_DOWN),
      .left   (bus.BTN_LEFT),
      .right  (bus.BTN_RIGHT),
      .en     (state_q != REQUEST),
      .cursor (cursor)
   );

   // Ownership uses the pre-move cursor, so CENTER with a direction pulse acts on the old square.
   assign cur_piece = sq_piece(bus.BOARD, cursor);
   assign own_cur   = (cur_piece.kind != PIECE_NONE) && (cur_piece.color == player_q);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         sel_addr_q <= '0;
         sel_en_q   <= 1'b0;
         src_q      <= '0;
         dst_q      <= '0;
         valid_q    <= 1'b0;
         player_q   <= FIRST_PLAYER;
      end else begin
         state_q    <= state_d;
         sel_addr_q <= sel_addr_d;
         sel_en_q   <= sel_en_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         valid_q    <= valid_d;
         player_q   <= player_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      sel_addr_d = sel_addr_q;
      sel_en_d   = sel_en_q;
      src_d      = src_q;
      dst_d      = dst_q;
      valid_d    = valid_q;
      player_d   = player_q;
      unique case (state_q)
         IDLE: begin
            if (bus.BTN_CENTER && own_cur) begin
               state_d    = SELECTED;
               sel_addr_d = cursor;
               sel_en_d   = 1'b1;
            end
         end
         SELECTED: begin
            if (bus.BTN_CENTER) begin
               if (cursor == sel_addr_q) begin
                  state_d  = IDLE;
                  sel_en_d = 1'b0;
               end else if (own_cur) begin
                  sel_addr_d = cursor;
               end else begin
                  state_d = REQUEST;
                  src_d   = sel_addr_q;
                  dst_d   = cursor;
                  valid_d = 1'b1;
               end
            end
         end
         REQUEST: begin
            if (bus.MOVE_READY) begin
               state_d  = IDLE;
               valid_d  = 1'b0;
               sel_en_d = 1'b0;
               if (bus.MOVE_LEGAL) player_d = ~player_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.CURSOR_ADDR = cursor;
   assign bus.SELECT_ADDR = sel_addr_q;
   assign bus.SELECT_EN   = sel_en_q;
   assign bus.MOVE_SRC    = src_q;
   assign bus.MOVE_DST    = dst_q;
   assign bus.MOVE_VALID  = valid_q;
   assign bus.PLAYER      = player_q;

endmodule
